ex_fwd_scoreboard: RTL
======================

Name: ex_fwd_scoreboard

Overview:
- Parametrised operand-forwarding and hazard unit for the execute stage.
- Tracks every in-flight producer across LANES issue lanes and STAGES post-EX1 pipeline stages (default: EX2, WB).
- Per stage slot, stores destination register, result data and a data-ready bit.
- Resolves each EX1 source operand to the youngest matching producer, or to the register-file value. Raises a stall when the youngest match is not yet computed.
- Accepts late completions (multiplier, divider, load) into slots already in flight.

Parameters:
- LANES, 2, number of issue lanes; lane L+1 is younger than lane L within a packet.
- STAGES, 2, number of tracked stages after EX1; stage 0 is youngest.
- XLEN, 32, data width.
- RAW, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- adv  in  1  downstream pipeline advances this cycle
- in_valid  in  LANES  EX1 lane holds a register-writing instruction
- in_rd  in  LANES*RAW  EX1 destination registers
- in_data  in  LANES*XLEN  EX1 results
- in_data_ok  in  LANES  EX1 result already computed (ALU/branch link)
- late_valid  in  1  late result write
- late_stage  in  $clog2(STAGES)  slot stage targeted by the late write
- late_lane  in  $clog2(LANES)  slot lane targeted by the late write
- late_data  in  XLEN  late result
- q_rs  in  LANES*2*RAW  EX1 source registers (rj, rk per lane)
- q_rf  in  LANES*2*XLEN  register-file read values
- q_out  out  LANES*2*XLEN  resolved operands
- stall  out  1  some source matches a not-ready producer
- ready_mask  out  STAGES*LANES  per-slot data-ready bits (debug)

Behaviour:
- State: STAGES×LANES slots, each holding {v, rd, data, ok}. Reset clears every v and ok. stall=0 and ready_mask=0 out of reset.
- Insert condition: ins = adv & ~stall. On ins, stage 0 loads the in_* values with v = in_valid and rd = in_rd.
- Bubble: on adv & stall, stage 0 loads all-invalid.
- Shift: on adv, stage s loads stage s-1. The last stage's contents retire (drop).
- Hold: with adv=0 all slots hold.
- Late write: when late_valid is high and the target slot has v=1, the slot gets data=late_data and ok=1. If adv is high in the same cycle, the write lands in the slot's post-shift position (stage+1). A write to the last stage with adv=1 is dropped. A write to a slot with v=0 is ignored.
- Resolution (combinational) for each source:
  - rs==0 gives q_rf value (zero register never forwarded).
  - Otherwise search youngest first: stage 0 before stage 1; within a stage, highest lane first. The first slot with v & rd==rs wins.
  - Match with ok=1: q_out=data. Match with ok=0: q_out=q_rf, and the source asserts its hazard bit.
  - No match: q_out=q_rf.
- stall = OR of all source hazard bits.
- Late data becomes forwardable the cycle after the write, not same-cycle.
- Intra-packet EX1 dependencies (lane1 reading lane0 rd) are excluded by the issue stage and are not checked here.
- Latency: query-to-output 0 cycles. Insert/late write visible next cycle.
- Reset mid-operation: all slots invalid next cycle and any stall drops.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cnt (32) and perf_fwd_cnt (32), both saturating and cleared by rst.
  - perf_stall_cnt increments on every cycle with stall=1.
  - perf_fwd_cnt increments once per cycle in which at least one source is served from a slot.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ex_fwd_pkg holds:
  - the slot struct typedef {v, rd, data, ok};
  - the LANES/STAGES/XLEN/RAW defaults;
  - the index-width function.
- One sub-module, ex_fwd_match: one source register plus the flattened slot array gives {hit, ok, data}. It is instantiated LANES*2 times.

Test Plan:
- Forward from stage 0: insert lane0 rd=5, data=0x11, ok=1, adv. Next cycle lane1 rs=5, q_rf=0xAA → q_out=0x11, stall=0.
- Youngest wins: stage1 rd=7 data=0x1, stage0 lane0 rd=7 data=0x2, stage0 lane1 rd=7 data=0x3; query rs=7 → 0x3.
- Not-ready producer: insert rd=9 with ok=0, then query rs=9 → stall=1 and stage-0 bubble on adv. Late write 0xDEAD to that slot in the same cycle as adv, now at stage 1 → next cycle q_out=0xDEAD, stall=0.
- Register r0: insert rd=0 data=0x55 ok=1; query rs=0 with q_rf=0 → q_out=0.
- Retirement: with STAGES=2, insert rd=3, then adv three times → query rs=3 returns q_rf. With adv=0 held 10 cycles, the match persists.
- Reset: with 4 valid slots and stall=1, assert rst one cycle → ready_mask=0, stall=0, all queries return q_rf.

Source files
------------

// File: rtl/ex_fwd_pkg.sv
// Shared definitions for the execute-stage forwarding scoreboard.
// Holds:
//   - the default configuration
//   - the slot layout at default widths
//   - the index-width helper used to size lane and stage selectors
package ex_fwd_pkg;
  localparam int LANES_DEF  = 2;
  localparam int STAGES_DEF = 2;
  localparam int XLEN_DEF   = 32;
  localparam int RAW_DEF    = 5;

  // One tracked producer. The scoreboard keeps these fields in separate
  // per-field arrays so that widths follow the module parameters.
  typedef struct packed {
    logic                v;
    logic [RAW_DEF-1:0]  rd;
    logic [XLEN_DEF-1:0] data;
    logic                ok;
  } slot_t;

  // Selector width for n entries. Never returns 0, so that single-entry
  // configurations still have a legal port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ex_fwd_match.sv
// Priority match of one source register against every tracked slot.
// Ports:
//   rs        - source register (r0 never matches)
//   slot_v    - flattened slot valid bits
//   slot_ok   - flattened slot data-ready bits
//   slot_rd   - flattened slot destination registers
//   slot_data - flattened slot result data
//   hit       - some valid slot writes rs
//   ok        - data of the winning slot is computed
//   data      - data of the winning slot
// Slot k = stage*LANES + lane. The youngest producer wins: stage 0
// before later stages, and the highest lane within a stage.
module ex_fwd_match
  import ex_fwd_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int XLEN   = XLEN_DEF,
  parameter int RAW    = RAW_DEF
) (
  input  logic [RAW-1:0]                rs,
  input  logic [STAGES*LANES-1:0]       slot_v,
  input  logic [STAGES*LANES-1:0]       slot_ok,
  input  logic [STAGES*LANES*RAW-1:0]   slot_rd,
  input  logic [STAGES*LANES*XLEN-1:0]  slot_data,
  output logic                          hit,
  output logic                          ok,
  output logic [XLEN-1:0]               data
);
  always_comb begin
    hit  = 1'b0;
    ok   = 1'b0;
    data = '0;
    // Scan from oldest to youngest. Later matches overwrite earlier ones,
    // so the youngest producer ends up selected.
    for (int s = STAGES-1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (rs != '0 && slot_v[s*LANES+l] &&
            slot_rd[(s*LANES+l)*RAW +: RAW] == rs) begin
          hit  = 1'b1;
          ok   = slot_ok[s*LANES+l];
          data = slot_data[(s*LANES+l)*XLEN +: XLEN];
        end
      end
    end
  end
endmodule

// File: rtl/ex_fwd_scoreboard.sv
// Operand forwarding and RAW hazard unit for the execute stage.
// Tracks every in-flight producer in STAGES x LANES slots after EX1.
// Resolves each EX1 source to the youngest producer, or to the register file.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   adv             - downstream pipeline advances this cycle
//   in_*            - EX1 producers. in_valid marks register writers;
//                     in_data_ok marks results that are already computed.
//   late_*          - late completion (mul/div/load) into an in-flight slot
//   q_rs, q_rf      - EX1 sources (rj, rk per lane) and register-file values
//   q_out           - resolved operands
//   stall           - some source matches a producer that is not yet ready
//   ready_mask      - per-slot data-ready bits, bit = stage*LANES + lane
// Optional macro FWD_PERF_CNT_EN adds two saturating counters:
//   perf_stall_cnt  - cycles with stall asserted
//   perf_fwd_cnt    - cycles where at least one source is served from a slot
module ex_fwd_scoreboard
  import ex_fwd_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int XLEN   = XLEN_DEF,
  parameter int RAW    = RAW_DEF,
  localparam int SW    = idx_w(STAGES),
  localparam int LW    = idx_w(LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*RAW-1:0]      in_rd,
  input  logic [LANES*XLEN-1:0]     in_data,
  input  logic [LANES-1:0]          in_data_ok,
  input  logic                      late_valid,
  input  logic [SW-1:0]             late_stage,
  input  logic [LW-1:0]             late_lane,
  input  logic [XLEN-1:0]           late_data,
  input  logic [LANES*2*RAW-1:0]    q_rs,
  input  logic [LANES*2*XLEN-1:0]   q_rf,
  output logic [LANES*2*XLEN-1:0]   q_out,
  output logic                      stall,
  output logic [STAGES*LANES-1:0]   ready_mask
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_fwd_cnt
`endif
);
  localparam int NSRC = LANES*2;

  logic [STAGES-1:0][LANES-1:0]            v_q, v_d, ok_q, ok_d;
  logic [STAGES-1:0][LANES-1:0][RAW-1:0]   rd_q, rd_d;
  logic [STAGES-1:0][LANES-1:0][XLEN-1:0]  data_q, data_d;

  logic [NSRC-1:0]                         hit, hit_ok;
  logic [NSRC-1:0][XLEN-1:0]               hit_data;
  logic [NSRC-1:0]                         haz;
  logic                                    ins;

  // Source j belongs to lane j/2; even j is rj, odd j is rk.
  for (genvar j = 0; j < NSRC; j++) begin : g_src
    ex_fwd_match #(
      .LANES (LANES),
      .STAGES(STAGES),
      .XLEN  (XLEN),
      .RAW   (RAW)
    ) u_match (
      .rs       (q_rs[j*RAW +: RAW]),
      .slot_v   (v_q),
      .slot_ok  (ok_q),
      .slot_rd  (rd_q),
      .slot_data(data_q),
      .hit      (hit[j]),
      .ok       (hit_ok[j]),
      .data     (hit_data[j])
    );
    assign haz[j] = hit[j] & ~hit_ok[j];
    assign q_out[j*XLEN +: XLEN] = (hit[j] && hit_ok[j]) ? hit_data[j]
                                                         : q_rf[j*XLEN +: XLEN];
  end

  assign stall      = |haz;
  assign ins        = adv & ~stall;
  assign ready_mask = ok_q;

  always_comb begin
    int ls, ll;
    v_d    = v_q;
    ok_d   = ok_q;
    rd_d   = rd_q;
    data_d = data_q;
    ls     = int'(late_stage);
    ll     = int'(late_lane);

    if (adv) begin
      for (int s = STAGES-1; s > 0; s--) begin
        v_d[s]    = v_q[s-1];
        ok_d[s]   = ok_q[s-1];
        rd_d[s]   = rd_q[s-1];
        data_d[s] = data_q[s-1];
      end
      // A stalled advance inserts a bubble; EX1 re-presents next cycle.
      for (int l = 0; l < LANES; l++) begin
        v_d[0][l]    = ins & in_valid[l];
        ok_d[0][l]   = ins & in_valid[l] & in_data_ok[l];
        rd_d[0][l]   = in_rd[l*RAW +: RAW];
        data_d[0][l] = in_data[l*XLEN +: XLEN];
      end
    end

    // The late write follows its slot. On an advance it lands one stage
    // further on, or it drops when the slot retires.
    if (late_valid && ls < STAGES && ll < LANES && v_q[ls][ll]) begin
      if (!adv) begin
        data_d[ls][ll] = late_data;
        ok_d[ls][ll]   = 1'b1;
      end else if (ls + 1 < STAGES) begin
        data_d[ls+1][ll] = late_data;
        ok_d[ls+1][ll]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      ok_q <= '0;
    end else begin
      v_q  <= v_d;
      ok_q <= ok_d;
    end
    rd_q   <= rd_d;
    data_q <= data_d;
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic        fwd_any;

  assign fwd_any = |(hit & hit_ok);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (fwd_any && !(&fwd_cnt_q)) fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`endif
endmodule
